pipe_dmem: RTL and testbench
============================

# pipe_dmem

Parametrised data memory for the MEM stage of the pipelined core, replacing the fixed 64-word, always-ready memory. It accepts one load/store request at a time over a valid/ready handshake and inserts a programmable number of wait states. It supports byte/half/word accesses with sign or zero extension, and reports misaligned or out-of-range accesses as errors instead of corrupting state. The pipeline stalls on `req_ready`/`resp_valid`.

## Interface
- `DATA_W`, 32: word width; fixed at 32 in this generation, with 4 byte lanes.
- `ADDR_W`, 8: byte-address width.
- `DEPTH`, 64: number of words; must satisfy DEPTH ≤ 2^(ADDR_W-2).
- `LATENCY`, 1: wait states between acceptance and response; range 0..15.

Ports (clock and reset first):
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out DATA_W: load result, extended.
- `resp_err` out 1: error flag, qualified by `resp_valid`.

## Operation
- Storage is DEPTH × DATA_W words. Word index is `req_addr[ADDR_W-1:2]`; byte lane is `req_addr[1:0]`.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, latch write, size, signed, addr and wdata, then go to WAIT if LATENCY>0, else RESP.
  - WAIT: counter loads LATENCY-1 on entry and decrements each cycle. At 0, go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then return to IDLE.
- `req_ready` = (state==IDLE). Inputs are ignored outside IDLE; `req_*` may change freely then.
- Error conditions, evaluated on the latched request:
  - word access with addr[1:0]≠0;
  - half access with addr[0]≠0;
  - size 11;
  - word index ≥ DEPTH.
- On error: no memory write, `resp_rdata`=0, `resp_err`=1.
- Store: on the edge entering RESP, write only the addressed lanes.
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0], little-endian (low byte at lower address).
  - Word: all lanes.
  - Other lanes are unchanged. Store response has `resp_rdata`=0.
- Load: on the edge entering RESP, register the selected lane(s) into `resp_rdata`, right-aligned, with bits above the size filled by the sign bit (`req_signed`=1) or zeros.
- `resp_rdata`/`resp_err` hold their values until the next response.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter 0, all memory words 0.
- Request accepted at edge t (valid & ready). `resp_valid` is high during cycle t+1+LATENCY. `req_ready` is high again at cycle t+2+LATENCY.
- Throughput: one request per LATENCY+2 cycles.
- Store and load in flight together is impossible (single outstanding request).
- A load issued after a store's response returns the stored data.
- Reset asserted mid-transaction: immediately abort to IDLE, drop the response, clear memory. An in-flight store is not performed.
- `req_valid` high in the same cycle as RESP is not accepted; it must be held until `req_ready`.

## Test plan
- After reset, LATENCY=1: load word 0x10 → `resp_valid` at t+2, `resp_rdata`=0x00000000, `resp_err`=0; `req_ready`=1 at t+3.
- Store word 0xDEADBEEF @0x20, then byte 0x7F @0x21, then load word @0x20 → 0xDEAD7FEF. Load byte signed @0x23 → 0xFFFFFFDE; load half unsigned @0x22 → 0x0000DEAD.
- Store word @0x22 (misaligned) → `resp_err`=1, `resp_rdata`=0, and a following load @0x20 still returns its prior value. With ADDR_W=9, DEPTH=64: access @0x100 → `resp_err`=1.
- LATENCY=0, then LATENCY=3: `resp_valid` exactly 1 and 4 cycles after acceptance. Back-to-back `req_valid` held high is accepted only every LATENCY+2 cycles.
- Assert reset during WAIT of a store word 0x12345678 @0x04 → no `resp_valid`, outputs zero; subsequent load @0x04 → 0x00000000.

Source files
------------

// File: rtl/pipe_dmem.sv
// MEM-stage data memory: one outstanding request over valid/ready, programmable wait
// states, byte/half/word access with sign/zero extension and error reporting.
module pipe_dmem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [1:0]        lat_size;
  logic              lat_signed;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              sel_write;
  logic [1:0]        sel_size;
  logic              sel_signed;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [MEM_AW-1:0] word_sel;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] load_data;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic              err;
  logic              enter_resp;

  // With zero wait states RESP is entered on the accept edge, so decode the live request there.
  always_comb begin
    if (state == IDLE) begin
      sel_write  = req_write;
      sel_size   = req_size;
      sel_signed = req_signed;
      sel_addr   = req_addr;
      sel_wdata  = req_wdata;
    end else begin
      sel_write  = lat_write;
      sel_size   = lat_size;
      sel_signed = lat_signed;
      sel_addr   = lat_addr;
      sel_wdata  = lat_wdata;
    end
  end

  assign idx      = sel_addr[ADDR_W-1:2];
  assign lane     = sel_addr[1:0];
  assign word_sel = idx[MEM_AW-1:0];
  assign rd_word  = mem[word_sel];

  assign enter_resp = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0));

  // Alignment, size and range checks.
  always_comb begin
    err = 1'b0;
    case (sel_size)
      2'b00:   err = 1'b0;
      2'b01:   err = lane[0];
      2'b10:   err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
    if ({1'b0, idx} >= (IDX_W + 1)'(DEPTH)) begin
      err = 1'b1;
    end else begin
      err = err;
    end
  end

  // Lane extraction and extension for loads.
  always_comb begin
    load_data = {DATA_W{1'b0}};
    load_byte = rd_word[{lane, 3'b000} +: 8];
    load_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (sel_size)
      2'b00:   load_data = {{24{sel_signed & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{sel_signed & load_half[15]}}, load_half};
      2'b10:   load_data = rd_word;
      default: load_data = {DATA_W{1'b0}};
    endcase
  end

  // Lane merge for stores; untouched lanes keep their old contents.
  always_comb begin
    wr_word = rd_word;
    case (sel_size)
      2'b00:   wr_word[{lane, 3'b000} +: 8]        = sel_wdata[7:0];
      2'b01:   wr_word[{lane[1], 4'b0000} +: 16]   = sel_wdata[15:0];
      2'b10:   wr_word                             = sel_wdata;
      default: wr_word                             = rd_word;
    endcase
  end

  // Storage; reset clears every word so an aborted store leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_W{1'b0}};
      end
    end else if (enter_resp && sel_write && !err) begin
      mem[word_sel] <= wr_word;
    end
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_addr   <= {ADDR_W{1'b0}};
      lat_wdata  <= {DATA_W{1'b0}};
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= {DATA_W{1'b0}};
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= enter_resp;
      if (enter_resp) begin
        resp_err   <= err;
        resp_rdata <= (sel_write || err) ? {DATA_W{1'b0}} : load_data;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_dmem.sv
// Directed bench for pipe_dmem: three instances (LATENCY 0, 1 with 9-bit addresses, 3)
// sharing request fields, each with its own req_valid.
module tb_pipe_dmem;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        v0, v1, v3;
  logic        r0, r1, r3;
  logic        rv0, rv1, rv3;
  logic        e0, e1, e3;
  logic [31:0] d0, d1, d3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_dmem #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(r0), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr[7:0]),
    .req_wdata(req_wdata), .resp_valid(rv0), .resp_rdata(d0), .resp_err(e0));

  pipe_dmem #(.DATA_W(32), .ADDR_W(9), .DEPTH(64), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(r1), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(d1), .resp_err(e1));

  pipe_dmem #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(r3), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr[7:0]),
    .req_wdata(req_wdata), .resp_valid(rv3), .resp_rdata(d3), .resp_err(e3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_valid(input int k, input logic b);
    case (k)
      0:       v0 = b;
      1:       v1 = b;
      default: v3 = b;
    endcase
  endtask

  task automatic snap(input int k, output logic rdy, output logic rv, output logic err,
                      output logic [31:0] rdata);
    case (k)
      0:       begin rdy = r0; rv = rv0; err = e0; rdata = d0; end
      1:       begin rdy = r1; rv = rv1; err = e1; rdata = d1; end
      default: begin rdy = r3; rv = rv3; err = e3; rdata = d3; end
    endcase
  endtask

  // One request; checks acceptance, response latency, data, error and pulse width.
  task automatic xact(input int k, input string tag, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [8:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    logic rdy, rv, err;
    logic [31:0] rdata;
    int n;
    @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    set_valid(k, 1'b1);
    snap(k, rdy, rv, err, rdata);
    check_eq({tag, "/ready_before"}, {31'd0, rdy}, 32'd1);
    @(posedge clk);
    #1;
    set_valid(k, 1'b0);
    n = 1;
    snap(k, rdy, rv, err, rdata);
    while (!rv && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      snap(k, rdy, rv, err, rdata);
    end
    check_eq({tag, "/latency"}, n, exp_lat);
    check_eq({tag, "/rdata"}, rdata, exp_d);
    check_eq({tag, "/err"}, {31'd0, err}, {31'd0, exp_e});
    check_eq({tag, "/ready_in_resp"}, {31'd0, rdy}, 32'd0);
    @(posedge clk);
    #1;
    snap(k, rdy, rv, err, rdata);
    check_eq({tag, "/pulse_end"}, {31'd0, rv}, 32'd0);
    check_eq({tag, "/ready_after"}, {31'd0, rdy}, 32'd1);
    check_eq({tag, "/rdata_hold"}, rdata, exp_d);
  endtask

  // Hold req_valid high and check accepts arrive exactly every exp_gap cycles.
  task automatic back_to_back(input int k, input string tag, input int cycles, input int exp_gap);
    logic rdy, rv, err;
    logic [31:0] rdata;
    int last = -1;
    int pulses = 0;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 9'h000; req_wdata = 32'd0;
    set_valid(k, 1'b1);
    for (int i = 0; i < cycles; i++) begin
      snap(k, rdy, rv, err, rdata);
      if (rdy) begin
        if (last >= 0) check_eq({tag, "/gap"}, i - last, exp_gap);
        last = i;
      end
      if (rv) pulses++;
      @(negedge clk);
    end
    set_valid(k, 1'b0);
    check_eq({tag, "/pulses"}, pulses, cycles / exp_gap);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic rdy, rv, err;
    logic [31:0] rdata;
    int pulses;
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v3 = 1'b0;
    req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 9'h000; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    snap(1, rdy, rv, err, rdata);
    check_eq("reset/ready", {31'd0, rdy}, 32'd1);
    check_eq("reset/resp_valid", {31'd0, rv}, 32'd0);
    check_eq("reset/rdata", rdata, 32'd0);
    check_eq("reset/err", {31'd0, err}, 32'd0);

    xact(1, "l1_load_0x10", 1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 32'h0000_0000, 1'b0, 2);
    xact(1, "st_word", 1'b1, 2'b10, 1'b0, 9'h020, 32'hDEAD_BEEF, 32'd0, 1'b0, 2);
    xact(1, "st_byte", 1'b1, 2'b00, 1'b0, 9'h021, 32'h1234_567F, 32'd0, 1'b0, 2);
    xact(1, "ld_word", 1'b0, 2'b10, 1'b0, 9'h020, 32'd0, 32'hDEAD_7FEF, 1'b0, 2);
    xact(1, "ld_byte_s", 1'b0, 2'b00, 1'b1, 9'h023, 32'd0, 32'hFFFF_FFDE, 1'b0, 2);
    xact(1, "ld_half_u", 1'b0, 2'b01, 1'b0, 9'h022, 32'd0, 32'h0000_DEAD, 1'b0, 2);
    xact(1, "ld_half_s", 1'b0, 2'b01, 1'b1, 9'h022, 32'd0, 32'hFFFF_DEAD, 1'b0, 2);
    xact(1, "ld_byte_u", 1'b0, 2'b00, 1'b0, 9'h021, 32'd0, 32'h0000_007F, 1'b0, 2);
    xact(1, "st_half", 1'b1, 2'b01, 1'b0, 9'h020, 32'hFFFF_8001, 32'd0, 1'b0, 2);
    xact(1, "ld_after_half", 1'b0, 2'b10, 1'b0, 9'h020, 32'd0, 32'hDEAD_8001, 1'b0, 2);
    xact(1, "st_misaligned", 1'b1, 2'b10, 1'b0, 9'h022, 32'h5555_AAAA, 32'd0, 1'b1, 2);
    xact(1, "ld_after_err", 1'b0, 2'b10, 1'b0, 9'h020, 32'd0, 32'hDEAD_8001, 1'b0, 2);
    xact(1, "ld_half_odd", 1'b0, 2'b01, 1'b0, 9'h021, 32'd0, 32'd0, 1'b1, 2);
    xact(1, "ld_size11", 1'b0, 2'b11, 1'b0, 9'h020, 32'd0, 32'd0, 1'b1, 2);
    xact(1, "st_out_of_range", 1'b1, 2'b10, 1'b0, 9'h100, 32'hCAFE_F00D, 32'd0, 1'b1, 2);
    xact(1, "ld_out_of_range", 1'b0, 2'b10, 1'b0, 9'h120, 32'd0, 32'd0, 1'b1, 2);
    xact(1, "ld_word0_no_alias", 1'b0, 2'b10, 1'b0, 9'h000, 32'd0, 32'd0, 1'b0, 2);
    xact(1, "st_last_word", 1'b1, 2'b10, 1'b0, 9'h0FC, 32'h0BAD_F00D, 32'd0, 1'b0, 2);
    xact(1, "ld_last_word", 1'b0, 2'b10, 1'b0, 9'h0FC, 32'd0, 32'h0BAD_F00D, 1'b0, 2);

    xact(0, "l0_st_word", 1'b1, 2'b10, 1'b0, 9'h008, 32'h1122_3344, 32'd0, 1'b0, 1);
    xact(0, "l0_ld_byte3", 1'b0, 2'b00, 1'b0, 9'h00B, 32'd0, 32'h0000_0011, 1'b0, 1);
    xact(0, "l0_ld_misaligned", 1'b0, 2'b10, 1'b0, 9'h00A, 32'd0, 32'd0, 1'b1, 1);
    xact(3, "l3_st_word", 1'b1, 2'b10, 1'b0, 9'h004, 32'hAABB_CCDD, 32'd0, 1'b0, 4);
    xact(3, "l3_ld_word", 1'b0, 2'b10, 1'b0, 9'h004, 32'd0, 32'hAABB_CCDD, 1'b0, 4);

    back_to_back(0, "btb_l0", 12, 2);
    back_to_back(3, "btb_l3", 20, 5);

    // Abort a LATENCY=3 store during WAIT; u_l3 still holds 0xAABBCCDD on resp_rdata.
    xact(3, "l3_ld_before_abort", 1'b0, 2'b10, 1'b0, 9'h004, 32'd0, 32'hAABB_CCDD, 1'b0, 4);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 9'h004; req_wdata = 32'h1234_5678;
    v3 = 1'b1;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    snap(3, rdy, rv, err, rdata);
    check_eq("abort/resp_valid", {31'd0, rv}, 32'd0);
    check_eq("abort/rdata", rdata, 32'd0);
    check_eq("abort/err", {31'd0, err}, 32'd0);
    check_eq("abort/ready", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rv3) pulses++;
    end
    check_eq("abort/no_resp", pulses, 0);
    xact(3, "abort/ld_after", 1'b0, 2'b10, 1'b0, 9'h004, 32'd0, 32'h0000_0000, 1'b0, 4);
    xact(1, "reset_cleared_l1", 1'b0, 2'b10, 1'b0, 9'h020, 32'd0, 32'h0000_0000, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
